// File: rtl/ifu_arb_pkg.sv
// Shared constants for the instruction-fetch memory arbiter: state encoding, way IDs and defaults.
// The optional watchdog is enabled with the IFU_ARB_TIMEOUT_EN macro.
package ifu_arb_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StDrop = 2'd2
    } arb_state_e;

    localparam logic WAY0 = 1'b0;
    localparam logic WAY1 = 1'b1;

    localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

    // Round-robin pointer only matters when both ways request together.
    function automatic logic pick_way(input logic req0, input logic req1, input logic rr_ptr);
        if (req0 && req1) begin
            return rr_ptr;
        end
        return req1 ? WAY1 : WAY0;
    endfunction

endpackage

// File: rtl/ifu_arb_watchdog.sv
// Watchdog for ifu_mem_arbiter: counts cycles spent with a request outstanding and raises a
// sticky error once the count reaches TIMEOUT_CYCLES. Built only with IFU_ARB_TIMEOUT_EN.
module ifu_arb_watchdog
    import ifu_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enter_i,
    input  logic active_i,
    output logic timeout_o
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout_q, timeout_d;

    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        if (enter_i) begin
            cnt_d = '0;
        end else if (active_i && (cnt_q != Limit)) begin
            // Saturate so the counter can never wrap back below the limit.
            cnt_d = cnt_q + CntW'(1);
        end
        if (active_i && (cnt_d == Limit)) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;

endmodule

// File: rtl/ifu_mem_arbiter.sv
// Round-robin arbiter sharing one instruction-memory read port between two fetch ways, with one
// transaction outstanding and flush draining. Optional watchdog: define IFU_ARB_TIMEOUT_EN.
module ifu_mem_arbiter
    import ifu_arb_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic              req1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic              flush_i,
    input  logic              mem_dataOk_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              mem_request_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              dataOk0_o,
    output logic              dataOk1_o,
    output logic [DATA_W-1:0] data_o,
    output logic              busy_o,
    output logic              timeout_o
);

    arb_state_e        state_q, state_d;
    logic              grant_q, grant_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        addr_d    = addr_q;
        dataOk0_o = 1'b0;
        dataOk1_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A flush in the same cycle wins over any new request.
                if (!flush_i && (req0_i || req1_i)) begin
                    grant_d = pick_way(req0_i, req1_i, rr_ptr_q);
                    addr_d  = (grant_d == WAY1) ? addr1_i : addr0_i;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (mem_dataOk_i) begin
                    if (!flush_i) begin
                        dataOk0_o = (grant_q == WAY0);
                        dataOk1_o = (grant_q == WAY1);
                    end
                    rr_ptr_d = ~grant_q;
                    state_d  = StIdle;
                end else if (flush_i) begin
                    state_d = StDrop;
                end
            end
            StDrop: begin
                // Memory cannot cancel, so the request stays up until the stale response lands.
                if (mem_dataOk_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            grant_q  <= WAY0;
            rr_ptr_q <= WAY0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            addr_q   <= addr_d;
        end
    end

    assign mem_request_o = (state_q != StIdle);
    assign mem_addr_o    = addr_q;
    assign busy_o        = (state_q != StIdle);
    assign data_o        = mem_data_i;

`ifdef IFU_ARB_TIMEOUT_EN
    logic wd_enter;
    assign wd_enter = (state_d != state_q) && (state_d != StIdle);

    ifu_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .reset_n  (reset_n),
        .enter_i  (wd_enter),
        .active_i (state_q != StIdle),
        .timeout_o(timeout_o)
    );
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_ifu_mem_arbiter.sv
// Scoreboard bench for ifu_mem_arbiter: directed stimulus pushes expected responses, a negedge
// monitor pops and compares them whenever a dataOk is presented.
module tb_ifu_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 8;
`ifdef IFU_ARB_TIMEOUT_EN
    localparam logic ToEn = 1'b1;
`else
    localparam logic ToEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req0_i, req1_i, flush_i;
    logic [AW-1:0] addr0_i, addr1_i;
    logic          mem_dataOk_i;
    logic [DW-1:0] mem_data_i;
    logic          mem_request_o, dataOk0_o, dataOk1_o, busy_o, timeout_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] data_o;

    ifu_mem_arbiter #(
        .ADDR_W        (AW),
        .DATA_W        (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req0_i       (req0_i),
        .addr0_i      (addr0_i),
        .req1_i       (req1_i),
        .addr1_i      (addr1_i),
        .flush_i      (flush_i),
        .mem_dataOk_i (mem_dataOk_i),
        .mem_data_i   (mem_data_i),
        .mem_request_o(mem_request_o),
        .mem_addr_o   (mem_addr_o),
        .dataOk0_o    (dataOk0_o),
        .dataOk1_o    (dataOk1_o),
        .data_o       (data_o),
        .busy_o       (busy_o),
        .timeout_o    (timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          way;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;
    int   resp_cnt    = 0;

    // Memory model: automatic responder with programmable latency, or manual drive.
    logic          mem_auto = 1'b0;
    int            mem_lat  = 0;
    int            wcnt     = 0;
    logic          auto_ok  = 1'b0;
    logic [DW-1:0] auto_data = '0;
    logic          man_ok   = 1'b0;
    logic [DW-1:0] man_data = '0;

    assign mem_dataOk_i = mem_auto ? auto_ok : man_ok;
    assign mem_data_i   = mem_auto ? auto_data : man_data;

    function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0013;
        return a ^ 32'hCAFE_0000;
    endfunction

    always @(posedge clk) begin
        #1;
        if (mem_request_o && reset_n) begin
            if (wcnt == mem_lat) begin
                auto_ok   = 1'b1;
                auto_data = mem_model(mem_addr_o);
                wcnt      = 0;
            end else begin
                auto_ok = 1'b0;
                wcnt++;
            end
        end else begin
            auto_ok = 1'b0;
            wcnt    = 0;
        end
    end

    always @(negedge clk) begin
        if (dataOk0_o && dataOk1_o) begin
            vectors++;
            miscompares++;
            $display("FAIL onehot: dataOk0=%b dataOk1=%b, required at most one", dataOk0_o,
                     dataOk1_o);
        end else if (dataOk0_o || dataOk1_o) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_resp: way%0d data=%h, required no response",
                         dataOk1_o, data_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (dataOk1_o !== mon_e.way || mem_addr_o !== mon_e.addr ||
                    data_o !== mon_e.data) begin
                    miscompares++;
                    $display("FAIL resp: way%0d addr=%h data=%h, required way%0d addr=%h data=%h",
                             dataOk1_o, mem_addr_o, data_o, mon_e.way, mon_e.addr, mon_e.data);
                end
            end
            resp_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic push(input logic way, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        exp_t e;
        e.way  = way;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic wait_resp(input int target, input int budget);
        int k = 0;
        while (resp_cnt < target && k < budget) begin
            tick();
            k++;
        end
        check("resp_wait_budget", 32'(resp_cnt >= target), 32'd1);
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        req0_i   = 1'b0;
        req1_i   = 1'b0;
        addr0_i  = '0;
        addr1_i  = '0;
        flush_i  = 1'b0;
        mem_auto = 1'b0;
        man_ok   = 1'b0;
        man_data = '0;
        repeat (2) tick();
        check("reset_outputs",
              {27'd0, mem_request_o, dataOk0_o, dataOk1_o, busy_o, timeout_o}, 32'd0);
        check("reset_addr", mem_addr_o, 32'd0);
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        int target;

        do_reset();

        // Single way0 fetch, zero-wait memory.
        mem_auto = 1'b1;
        mem_lat  = 0;
        push(1'b0, 32'h8000_0000, 32'h0000_0013);
        req0_i  = 1'b1;
        addr0_i = 32'h8000_0000;
        check("issue_latency_low", 32'(mem_request_o), 32'd0);
        tick();
        check("issue_latency_high", 32'(mem_request_o), 32'd1);
        check("first_addr", mem_addr_o, 32'h8000_0000);
        check("way1_quiet", 32'(dataOk1_o), 32'd0);
        req0_i = 1'b0;
        tick();
        check("idle_after_first", 32'(busy_o), 32'd0);

        // Both ways held, latency 2: way0, way1, way0.
        do_reset();
        mem_auto = 1'b1;
        mem_lat  = 2;
        push(1'b0, 32'h100, 32'hCAFE_0100);
        push(1'b1, 32'h104, 32'hCAFE_0104);
        push(1'b0, 32'h100, 32'hCAFE_0100);
        target  = resp_cnt + 3;
        req0_i  = 1'b1;
        req1_i  = 1'b1;
        addr0_i = 32'h100;
        addr1_i = 32'h104;
        wait_resp(target, 40);
        req0_i = 1'b0;
        req1_i = 1'b0;
        tick();
        check("idle_after_rr", 32'(busy_o), 32'd0);

        // Flush in WAIT before the response: drain through DROP.
        mem_auto = 1'b0;
        req0_i   = 1'b1;
        addr0_i  = 32'h200;
        tick();
        check("wait_busy", 32'(busy_o), 32'd1);
        flush_i = 1'b1;
        req0_i  = 1'b0;
        tick();
        flush_i = 1'b0;
        check("drop_req_held", 32'(mem_request_o), 32'd1);
        check("drop_addr_held", mem_addr_o, 32'h200);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("drop_second_flush", 32'(mem_request_o), 32'd1);
        man_ok   = 1'b1;
        man_data = 32'hDEAD_0000;
        check("drop_no_dataok", {30'd0, dataOk0_o, dataOk1_o}, 32'd0);
        tick();
        man_ok = 1'b0;
        check("drop_to_idle", 32'(busy_o), 32'd0);
        mem_auto = 1'b1;
        mem_lat  = 0;
        push(1'b1, 32'h300, 32'hCAFE_0300);
        req1_i  = 1'b1;
        addr1_i = 32'h300;
        tick();
        req1_i = 1'b0;
        tick();

        // Flush together with the response: dropped, pointer still toggles to way1.
        mem_auto = 1'b0;
        req0_i   = 1'b1;
        addr0_i  = 32'h400;
        tick();
        flush_i = 1'b1;
        man_ok  = 1'b1;
        req0_i  = 1'b0;
        check("flush_ok_dropped", {30'd0, dataOk0_o, dataOk1_o}, 32'd0);
        tick();
        flush_i = 1'b0;
        man_ok  = 1'b0;
        check("flush_ok_idle", 32'(busy_o), 32'd0);
        mem_auto = 1'b1;
        push(1'b1, 32'h504, 32'hCAFE_0504);
        req0_i  = 1'b1;
        req1_i  = 1'b1;
        addr0_i = 32'h500;
        addr1_i = 32'h504;
        tick();
        check("rr_toggled_addr", mem_addr_o, 32'h504);
        req0_i = 1'b0;
        req1_i = 1'b0;
        tick();

        // Asynchronous reset mid-transaction; late response ignored.
        mem_auto = 1'b0;
        req0_i   = 1'b1;
        addr0_i  = 32'h600;
        tick();
        check("pre_reset_req", 32'(mem_request_o), 32'd1);
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs", {28'd0, mem_request_o, dataOk0_o, dataOk1_o, busy_o},
              32'd0);
        check("async_reset_addr", mem_addr_o, 32'd0);
        req0_i = 1'b0;
        tick();
        reset_n  = 1'b1;
        man_ok   = 1'b1;
        man_data = 32'h0000_1234;
        check("late_resp_ignored", {30'd0, dataOk0_o, dataOk1_o}, 32'd0);
        tick();
        man_ok = 1'b0;
        check("late_resp_idle", 32'(busy_o), 32'd0);

        // Memory stalls: watchdog behaviour.
        req0_i  = 1'b1;
        addr0_i = 32'h700;
        tick();
        repeat (7) tick();
        check("timeout_before_limit", 32'(timeout_o), 32'd0);
        tick();
        check("timeout_at_limit", 32'(timeout_o), 32'(ToEn));
        repeat (5) tick();
        check("timeout_sticky_wait", 32'(timeout_o), 32'(ToEn));
        push(1'b0, 32'h700, 32'h0000_0077);
        man_ok   = 1'b1;
        man_data = 32'h0000_0077;
        req0_i   = 1'b0;
        tick();
        man_ok = 1'b0;
        tick();
        check("timeout_sticky_idle", 32'(timeout_o), 32'(ToEn));
        check("final_idle", 32'(busy_o), 32'd0);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
